// File: rtl/trace_serialiser_if.sv
// Bundles the record input, output stream handshake and status of trace_serialiser.
// master is the serialiser side; slave is the tracker/sink environment.
interface trace_serialiser_if #(
  parameter int TRACE_W = 512,
  parameter int DEPTH   = 4
) ();
  logic [TRACE_W-1:0]         trace_i;
  logic                       trace_valid_i;
  logic [31:0]                out_data_o;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic                       out_last_o;
  logic [$clog2(DEPTH+1)-1:0] fifo_count_o;
  logic                       overflow_o;
  logic [15:0]                drop_count_o;

  modport master (
    input  trace_i, trace_valid_i, out_ready_i,
    output out_data_o, out_valid_o, out_last_o, fifo_count_o, overflow_o, drop_count_o
  );

  modport slave (
    output trace_i, trace_valid_i, out_ready_i,
    input  out_data_o, out_valid_o, out_last_o, fifo_count_o, overflow_o, drop_count_o
  );
endinterface

// File: rtl/trace_serialiser.sv
// Buffers trace records in a small FIFO and streams each one as a header word
// followed by ceil(TRACE_W/32) payload words; records arriving while full are dropped.
module trace_serialiser #(
  parameter int TRACE_W = 512,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  trace_serialiser_if.master bus
);

  localparam int N     = (TRACE_W + 31) / 32;
  localparam int PW    = N * 32;
  localparam int KW    = (N > 1) ? $clog2(N) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [7:0] N_BYTE = 8'(N);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [KW-1:0]      k_q, k_d;
  logic [7:0]         seq_q, seq_d;
  logic [7:0]         hdr_drop_q, hdr_drop_d;
  logic [15:0]        drop_count_q, drop_count_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [TRACE_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]      head_pad;
  logic [31:0]        head_words [N];
  logic [KW-1:0]      next_idx;
  logic               next_last;
  logic               fire, k_last, pop, push, drop, full, hdr_load;

  // Head record zero-extended to whole words so the payload mux never reads past TRACE_W.
  always_comb begin
    head_pad = '0;
    head_pad[TRACE_W-1:0] = mem_q[rd_ptr_q];
    for (int w = 0; w < N; w++) begin
      head_words[w] = head_pad[w*32 +: 32];
    end
  end

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    fire      = valid_q && bus.out_ready_i;
    k_last    = (int'(k_q) == N - 1);
    pop       = (state_q == PAYLOAD) && fire && k_last;
    push      = bus.trace_valid_i && (!full || pop);
    drop      = bus.trace_valid_i && !push;
    hdr_load  = (state_q == IDLE) && (count_q != '0);
    next_idx  = (state_q == HEADER) ? '0 : k_q + KW'(1);
    next_last = (int'(next_idx) == N - 1);
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    valid_d      = valid_q;
    last_d       = last_q;
    k_d          = k_q;
    seq_d        = seq_q;
    hdr_drop_d   = hdr_drop_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end

    // A drop on the header load edge belongs to the next header, not the one being built.
    if (hdr_load) begin
      hdr_drop_d = {7'd0, drop};
    end else if (drop && hdr_drop_q != 8'hFF) begin
      hdr_drop_d = hdr_drop_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (hdr_load) begin
          data_d  = {8'hA5, seq_q, hdr_drop_q, N_BYTE};
          valid_d = 1'b1;
          last_d  = 1'b0;
          seq_d   = seq_q + 8'd1;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (fire) begin
          data_d  = head_words[next_idx];
          last_d  = next_last;
          k_d     = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (fire) begin
          if (k_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            data_d = head_words[next_idx];
            last_d = next_last;
            k_d    = next_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      k_q          <= '0;
      seq_q        <= '0;
      hdr_drop_q   <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      k_q          <= k_d;
      seq_q        <= seq_d;
      hdr_drop_q   <= hdr_drop_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Record storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.trace_i;
  end

  assign bus.out_data_o   = data_q;
  assign bus.out_valid_o  = valid_q;
  assign bus.out_last_o   = last_q;
  assign bus.fifo_count_o = count_q;
  assign bus.overflow_o   = overflow_q;
  assign bus.drop_count_o = drop_count_q;

endmodule

// File: tb/tb_trace_serialiser.sv
// Self-checking bench for trace_serialiser: a packet-level queue model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_trace_serialiser;

  localparam int TW = 64;
  localparam int DP = 4;
  localparam int NW = (TW + 31) / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_serialiser_if #(.TRACE_W(TW), .DEPTH(DP)) bus ();

  trace_serialiser #(.TRACE_W(TW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [TW-1:0] m_fifo [$];
  logic [31:0]   m_pkt  [$];
  int            m_seq      = 0;
  int            m_hdrdrops = 0;
  int            m_drops    = 0;
  bit            m_ovf      = 1'b0;

  logic [31:0]   hdrs [$];
  int            hs_count  = 0;
  bit            at_header = 1'b1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pkt.delete();
    m_seq      = 0;
    m_hdrdrops = 0;
    m_drops    = 0;
    m_ovf      = 1'b0;
  endtask

  // One clock edge of the packet model: whole packets are built when a header is due.
  task automatic model_step();
    bit fire, pop, load, accept, drop;
    logic [NW*32-1:0] padded;
    fire   = (m_pkt.size() > 0) && bus.out_ready_i;
    pop    = fire && (m_pkt.size() == 1);
    load   = (m_pkt.size() == 0) && (m_fifo.size() > 0);
    accept = bus.trace_valid_i && ((m_fifo.size() < DP) || pop);
    drop   = bus.trace_valid_i && !accept;
    if (load) begin
      padded = '0;
      padded[TW-1:0] = m_fifo[0];
      m_pkt.push_back({8'hA5, 8'(m_seq), 8'(m_hdrdrops), 8'(NW)});
      for (int k = 0; k < NW; k++) m_pkt.push_back(32'(padded >> (32 * k)));
      m_seq      = (m_seq + 1) % 256;
      m_hdrdrops = drop ? 1 : 0;
    end else if (drop && m_hdrdrops < 255) begin
      m_hdrdrops++;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end
    if (fire)   void'(m_pkt.pop_front());
    if (pop)    void'(m_fifo.pop_front());
    if (accept) m_fifo.push_back(bus.trace_i);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Compare process: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      at_header = 1'b1;
    end else begin
      checkOutput("out_valid", 64'(bus.out_valid_o), 64'(m_pkt.size() > 0));
      if (m_pkt.size() > 0) begin
        checkOutput("out_data", 64'(bus.out_data_o), 64'(m_pkt[0]));
        checkOutput("out_last", 64'(bus.out_last_o), 64'(m_pkt.size() == 1));
      end
      checkOutput("fifo_count", 64'(bus.fifo_count_o), 64'(m_fifo.size()));
      checkOutput("overflow", 64'(bus.overflow_o), 64'(m_ovf));
      checkOutput("drop_count", 64'(bus.drop_count_o), 64'(m_drops));
      if (bus.out_valid_o && bus.out_ready_i) begin
        hs_count++;
        if (at_header) hdrs.push_back(bus.out_data_o);
        at_header = bus.out_last_o;
      end
    end
  end

  task automatic applyStimulus(input logic strobe, input logic [TW-1:0] rec, input logic ready);
    bus.trace_valid_i = strobe;
    bus.trace_i       = rec;
    bus.out_ready_i   = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [TW-1:0] rand_rec();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int hs_start;
    applyStimulus(1'b0, '0, 1'b0);
    step();
    doReset();

    // Reset state.
    checkOutput("rst_data", 64'(bus.out_data_o), 64'h0);
    checkOutput("rst_valid", 64'(bus.out_valid_o), 64'h0);
    checkOutput("rst_last", 64'(bus.out_last_o), 64'h0);
    checkOutput("rst_count", 64'(bus.fifo_count_o), 64'h0);
    checkOutput("rst_overflow", 64'(bus.overflow_o), 64'h0);
    checkOutput("rst_drops", 64'(bus.drop_count_o), 64'h0);

    // Single record with an always-ready sink.
    applyStimulus(1'b1, 64'h1122334455667788, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("single_T1_valid", 64'(bus.out_valid_o), 64'h0);
    step();
    checkOutput("single_hdr", 64'(bus.out_data_o), 64'hA5000002);
    checkOutput("single_hdr_valid", 64'(bus.out_valid_o), 64'h1);
    step();
    checkOutput("single_w0", 64'(bus.out_data_o), 64'h55667788);
    checkOutput("single_w0_last", 64'(bus.out_last_o), 64'h0);
    step();
    checkOutput("single_w1", 64'(bus.out_data_o), 64'h11223344);
    checkOutput("single_w1_last", 64'(bus.out_last_o), 64'h1);
    step();
    checkOutput("single_T5_valid", 64'(bus.out_valid_o), 64'h0);
    repeat (3) step();

    // Backpressure on payload word 0 for five cycles.
    doReset();
    hs_start = hs_count;
    applyStimulus(1'b1, 64'hCAFEBABEDEADBEEF, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    step();
    step();
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_data", 64'(bus.out_data_o), 64'hDEADBEEF);
      checkOutput("stall_last", 64'(bus.out_last_o), 64'h0);
      checkOutput("stall_valid", 64'(bus.out_valid_o), 64'h1);
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (4) step();
    checkOutput("stall_word_count", 64'(hs_count - hs_start), 64'(NW + 1));

    // Overflow: six back-to-back strobes into a stalled sink.
    doReset();
    hdrs.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, rand_rec(), 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("ovf_count", 64'(bus.fifo_count_o), 64'd4);
    checkOutput("ovf_drops", 64'(bus.drop_count_o), 64'd2);
    checkOutput("ovf_flag", 64'(bus.overflow_o), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    repeat (20) step();
    checkOutput("ovf_num_headers", 64'(hdrs.size()), 64'd4);
    if (hdrs.size() >= 2) begin
      checkOutput("ovf_hdr0_drops", 64'(hdrs[0][15:8]), 64'd0);
      checkOutput("ovf_hdr1_drops", 64'(hdrs[1][15:8]), 64'd2);
    end

    // Full FIFO with a strobe on the same edge as the last-word handshake.
    doReset();
    for (int i = 0; i < DP; i++) begin
      applyStimulus(1'b1, rand_rec(), 1'b0);
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid_o && bus.out_last_o) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checkOutput("collide_found_last", 64'(found), 64'd1);
    applyStimulus(1'b1, rand_rec(), 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("collide_drops", 64'(bus.drop_count_o), 64'd0);
    checkOutput("collide_count", 64'(bus.fifo_count_o), 64'(DP));
    repeat (25) step();

    // Sequence wrap over 257 paced records.
    doReset();
    hdrs.delete();
    for (int i = 0; i < 257; i++) begin
      applyStimulus(1'b1, rand_rec(), 1'b1);
      step();
      applyStimulus(1'b0, '0, 1'b1);
      repeat (4) step();
    end
    repeat (10) step();
    checkOutput("wrap_num_headers", 64'(hdrs.size()), 64'd257);
    for (int i = 0; i < hdrs.size() && i < 257; i++) begin
      checkOutput("wrap_seq", 64'(hdrs[i][23:16]), 64'(i % 256));
    end

    // Reset after the header and one payload word, with a second record queued.
    doReset();
    applyStimulus(1'b1, rand_rec(), 1'b1);
    step();
    applyStimulus(1'b1, rand_rec(), 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 64'(bus.out_valid_o), 64'd0);
    checkOutput("midrst_count", 64'(bus.fifo_count_o), 64'd0);
    step();
    rst = 1'b0;
    applyStimulus(1'b1, rand_rec(), 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    step();
    checkOutput("midrst_new_valid", 64'(bus.out_valid_o), 64'd1);
    checkOutput("midrst_new_seq", 64'(bus.out_data_o[23:16]), 64'h00);
    checkOutput("midrst_new_sync", 64'(bus.out_data_o[31:24]), 64'hA5);
    repeat (5) step();

    // Randomized traffic checked against the model every cycle.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 40), rand_rec(), 1'($urandom_range(0, 99) < 75));
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    repeat (40) step();
    checkOutput("drain_count", 64'(bus.fifo_count_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
